// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the mac_seq neuron-lane controller.
package mac_seq_pkg;

    localparam int OPND_W = 8;
    localparam int ACC_W  = 16;
    localparam int OUT_W  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ACC  = 3'd2,
        CAPT = 3'd3,
        OUT  = 3'd4
    } state_e;

endpackage

// File: rtl/mac_seq_if.sv
// Bundle of operand stream, MAC drive/return and result stream for one neuron lane.
interface mac_seq_if;
    import mac_seq_pkg::*;

    logic              start;
    logic [OPND_W-1:0] bias_in;
    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] in_a;
    logic [OPND_W-1:0] in_b;
    logic              mac_load;
    logic              mac_en;
    logic [OPND_W-1:0] mac_a;
    logic [OPND_W-1:0] mac_b;
    logic [OPND_W-1:0] mac_bias;
    logic [ACC_W-1:0]  mac_result;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [ACC_W-1:0]  out_raw;
    logic              busy;

    // Controller side
    modport master (
        input  start, bias_in, in_valid, in_a, in_b, mac_result, out_ready,
        output in_ready, mac_load, mac_en, mac_a, mac_b, mac_bias,
               out_valid, out_data, out_raw, busy
    );

    // Environment side: operand source, MAC and result sink
    modport slave (
        output start, bias_in, in_valid, in_a, in_b, mac_result, out_ready,
        input  in_ready, mac_load, mac_en, mac_a, mac_b, mac_bias,
               out_valid, out_data, out_raw, busy
    );

endinterface

// File: rtl/mac_seq_requant.sv
// Requantizes the 16-bit sum to 8 bits by a fixed right shift.
// With MAC_SEQ_SAT_EN defined the result clamps at 255, otherwise it wraps.
module mac_seq_requant
    import mac_seq_pkg::*;
#(
    parameter int OUT_SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] q
);

    logic [ACC_W-1:0] shifted_s;

    // Shift, then clamp or truncate to the output width
    always_comb begin
        shifted_s = acc >> OUT_SHIFT;
`ifdef MAC_SEQ_SAT_EN
        if (shifted_s > 16'd255) begin
            q = 8'hFF;
        end else begin
            q = shifted_s[OUT_W-1:0];
        end
`else
        q = shifted_s[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_seq.sv
// Sequencer for one bias-preloaded MAC lane: load bias, stream N_IN pairs, return requantized sum.
// Output saturation is selected by MAC_SEQ_SAT_EN (see mac_seq_requant).
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int N_IN      = 784,
    parameter int CNT_W     = $clog2(N_IN) + 1,
    parameter int OUT_SHIFT = 8
) (
    input  logic     clkext,
    input  logic     rst_n,
    mac_seq_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [OPND_W-1:0] bias_r;
    logic [ACC_W-1:0]  raw_r;
    logic [OUT_W-1:0]  data_r;
    logic              in_ready_r;
    logic              mac_load_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              fire_s;
    logic [OUT_W-1:0]  q_s;

    mac_seq_requant #(.OUT_SHIFT(OUT_SHIFT)) u_requant (
        .acc (bus.mac_result),
        .q   (q_s)
    );

    // A beat is accepted only while the ACC-state ready flag is up
    assign fire_s = bus.in_valid & in_ready_r;

    // Control FSM; status flags are registered alongside the state transition
    always_ff @(posedge clkext or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bias_r      <= 8'h00;
            raw_r       <= 16'h0000;
            data_r      <= 8'h00;
            in_ready_r  <= 1'b0;
            mac_load_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        bias_r     <= bus.bias_in;
                        cnt_r      <= {CNT_W{1'b0}};
                        mac_load_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    mac_load_r <= 1'b0;
                    in_ready_r <= 1'b1;
                    state_r    <= ACC;
                end
                ACC: begin
                    if (fire_s) begin
                        if (cnt_r == LAST_BEAT) begin
                            in_ready_r <= 1'b0;
                            state_r    <= CAPT;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                CAPT: begin
                    // The MAC registered the last product on the previous edge
                    raw_r       <= bus.mac_result;
                    data_r      <= q_s;
                    out_valid_r <= 1'b1;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b0;
                    mac_load_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mac_load  = mac_load_r;
    assign bus.mac_en    = fire_s;
    assign bus.mac_a     = fire_s ? bus.in_a : 8'h00;
    assign bus.mac_b     = fire_s ? bus.in_b : 8'h00;
    assign bus.mac_bias  = bias_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_r;
    assign bus.out_raw   = raw_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mac_seq.sv
// Directed plus randomized bench for mac_seq: two lanes (N_IN=4/OUT_SHIFT=2 and N_IN=1/OUT_SHIFT=0).
module tb_mac_seq;
    import mac_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_seq_if i4();
    mac_seq_if i1();

    mac_seq #(.N_IN(4), .OUT_SHIFT(2)) u4 (.clkext(clk), .rst_n(rst_n), .bus(i4.master));
    mac_seq #(.N_IN(1), .OUT_SHIFT(0)) u1 (.clkext(clk), .rst_n(rst_n), .bus(i1.master));

    // Behavioural MACs obeying the load/enable contract
    logic [15:0] acc4, acc1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc4 <= 16'd0;
        else if (i4.mac_load) acc4 <= {8'd0, i4.mac_bias};
        else if (i4.mac_en) acc4 <= acc4 + i4.mac_a * i4.mac_b;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc1 <= 16'd0;
        else if (i1.mac_load) acc1 <= {8'd0, i1.mac_bias};
        else if (i1.mac_en) acc1 <= acc1 + i1.mac_a * i1.mac_b;
    end
    assign i4.mac_result = acc4;
    assign i1.mac_result = acc1;

    // Pulse counters and protocol monitor for the 4-beat lane
    int nload4 = 0, nen4 = 0, proto_bad = 0;
    always @(posedge clk) begin
        if (rst_n) begin
            nload4 <= nload4 + int'(i4.mac_load);
            nen4   <= nen4 + int'(i4.mac_en);
            if (i4.mac_en !== (i4.in_valid & i4.in_ready)) proto_bad <= proto_bad + 1;
            if (!i4.mac_en && (i4.mac_a !== 8'd0 || i4.mac_b !== 8'd0)) proto_bad <= proto_bad + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] pa[4];
    logic [7:0] pb[4];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product plus bias, wrapped to 16 bits like the MAC
    function automatic logic [15:0] ref_sum(input logic [7:0] bias, input int n);
        int s;
        s = int'(bias);
        for (int k = 0; k < n; k++) s += int'(pa[k]) * int'(pb[k]);
        return 16'(s % 65536);
    endfunction

    function automatic logic [7:0] ref_q(input logic [15:0] s, input int sh);
        int v;
        v = int'(s) / (1 << sh);
`ifdef MAC_SEQ_SAT_EN
        if (v > 255) return 8'd255;
`endif
        return 8'(v % 256);
    endfunction

    // Offer pair k until the lane accepts it (bounded)
    task automatic fire4(input string tag, input int k, output int cyc);
        bit f;
        f = 1'b0;
        cyc = 0;
        i4.in_valid = 1'b1;
        i4.in_a = pa[k];
        i4.in_b = pb[k];
        for (int t = 0; t < 20 && !f; t++) begin
            #3;
            f = i4.in_ready;
            step;
            cyc++;
        end
        if (!f) chk({tag, ".fire_timeout"}, 32'(f), 32'd1);
    endtask

    task automatic run4(input string tag, input logic [7:0] bias, input int gap, input bit hold_out);
        logic [15:0] es;
        logic [7:0]  eq;
        int l0, e0, cyc, c;
        es = ref_sum(bias, 4);
        eq = ref_q(es, 2);
        l0 = nload4;
        e0 = nen4;
        i4.bias_in = bias;
        i4.start = 1'b1;
        step;
        i4.start = 1'b0;
        cyc = 1;
        chk({tag, ".busy"}, 32'(i4.busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                i4.in_valid = 1'b0;
                i4.in_a = $urandom_range(0, 255);
                i4.in_b = $urandom_range(0, 255);
                step;
                cyc++;
            end
            fire4(tag, k, c);
            cyc += c;
        end
        i4.in_valid = 1'b0;
        i4.in_a = 8'd0;
        i4.in_b = 8'd0;
        chk({tag, ".capt_no_valid"}, 32'(i4.out_valid), 32'd0);
        step;
        cyc++;
        chk({tag, ".valid_at_fire+2"}, 32'(i4.out_valid), 32'd1);
        if (gap == 0) chk({tag, ".turnaround"}, 32'(cyc), 32'd7);
        chk({tag, ".raw"}, 32'(i4.out_raw), 32'(es));
        chk({tag, ".data"}, 32'(i4.out_data), 32'(eq));
        chk({tag, ".load_pulses"}, 32'(nload4 - l0), 32'd1);
        chk({tag, ".en_pulses"}, 32'(nen4 - e0), 32'd4);
        if (!hold_out) begin
            step;
            chk({tag, ".idle"}, {30'd0, i4.out_valid, i4.busy}, 32'd0);
        end
    endtask

    task automatic set_basic;
        pa[0] = 8'd1; pb[0] = 8'd2;
        pa[1] = 8'd3; pb[1] = 8'd4;
        pa[2] = 8'd5; pb[2] = 8'd6;
        pa[3] = 8'd7; pb[3] = 8'd8;
    endtask

    initial begin
        int c, seen;
        logic [7:0] rb;
        i4.start = 1'b0; i4.bias_in = 8'd0; i4.in_valid = 1'b0; i4.in_a = 8'd0; i4.in_b = 8'd0; i4.out_ready = 1'b1;
        i1.start = 1'b0; i1.bias_in = 8'd0; i1.in_valid = 1'b0; i1.in_a = 8'd0; i1.in_b = 8'd0; i1.out_ready = 1'b1;
        #2;
        chk("rst.ctrl", {27'd0, i4.in_ready, i4.mac_load, i4.mac_en, i4.out_valid, i4.busy}, 32'd0);
        chk("rst.data", {i4.mac_bias, i4.out_data, i4.out_raw}, 32'd0);
        #20 rst_n = 1'b1;
        step;

        set_basic;
        run4("basic", 8'd10, 0, 1'b0);
        run4("stall", 8'd10, 3, 1'b0);
        chk("stall.protocol", 32'(proto_bad), 32'd0);

        // Output backpressure with STARTs that must be ignored
        i4.out_ready = 1'b0;
        run4("bp", 8'd10, 0, 1'b1);
        for (int w = 0; w < 5; w++) begin
            i4.start = w[0];
            i4.bias_in = 8'd99;
            step;
            chk("bp.hold", {i4.out_valid, i4.busy, 6'd0, i4.out_data, i4.out_raw}, {1'b1, 1'b1, 6'd0, 8'd27, 16'd110});
        end
        i4.start = 1'b0;
        i4.out_ready = 1'b1;
        step;
        chk("bp.release", 32'(i4.out_valid), 32'd0);
        step;
        chk("bp.no_queue", {30'd0, i4.busy, i4.mac_load}, 32'd0);

        // Saturation / wrap
        for (int k = 0; k < 4; k++) begin pa[k] = 8'd32; pb[k] = 8'd32; end
        run4("sat", 8'd0, 0, 1'b0);

        // Reset in the middle of accumulation
        set_basic;
        i4.bias_in = 8'd10;
        i4.start = 1'b1;
        step;
        i4.start = 1'b0;
        fire4("rst", 0, c);
        fire4("rst", 1, c);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.ctrl", {27'd0, i4.in_ready, i4.mac_load, i4.mac_en, i4.out_valid, i4.busy}, 32'd0);
        chk("rst_mid.data", {i4.mac_bias, i4.mac_a, i4.mac_b, i4.out_data}, 32'd0);
        chk("rst_mid.raw", 32'(i4.out_raw), 32'd0);
        i4.in_valid = 1'b0;
        step;
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            step;
            seen += int'(i4.out_valid);
        end
        chk("rst_mid.no_valid", 32'(seen), 32'd0);
        run4("after_rst", 8'd10, 0, 1'b0);

        // Randomized dot products against the reference model
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                pa[k] = 8'($urandom_range(0, 255));
                pb[k] = 8'($urandom_range(0, 255));
            end
            rb = 8'($urandom_range(0, 255));
            run4("rand", rb, int'($urandom_range(0, 2)), 1'b0);
        end
        chk("rand.protocol", 32'(proto_bad), 32'd0);

        // Single-beat lane with IN_VALID pre-asserted
        i1.in_valid = 1'b1;
        i1.in_a = 8'd200;
        i1.in_b = 8'd1;
        i1.bias_in = 8'd3;
        i1.start = 1'b1;
        step;
        i1.start = 1'b0;
        c = 1;
        while (!i1.out_valid && c < 20) begin
            step;
            c++;
        end
        i1.in_valid = 1'b0;
        chk("n1.latency", 32'(c), 32'd4);
        chk("n1.raw", 32'(i1.out_raw), 32'd203);
        chk("n1.data", 32'(i1.out_data), 32'(ref_q(16'd203, 0)));
        i1.start = 1'b1;
        step;
        i1.start = 1'b0;
        chk("n1.handshake", {30'd0, i1.out_valid, i1.busy}, 32'd0);
        step;
        chk("n1.start_in_out_ignored", {30'd0, i1.busy, i1.mac_load}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
